// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type, bit-timing helper and
// link defaults common to the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD      = 115_200;
  localparam int DEFAULT_DATA_BITS = 8;

  // Clock cycles per line bit; truncating division, so the bit period rounds down.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Restartable bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
// flags the terminal count with bit_tick. The receiver reuses this for
// mid-bit sampling.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick = enable && (count == TERMINAL);

  // Count within the current bit; wrap at terminal count, restart on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches a word on an accepted start pulse and
// sends start bit, data LSB first, optional parity and 1 or 2 stop bits.
// All outputs are registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BIT_CNT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_serializer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_t              state, state_next;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   par_bit, par_next;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next;
  logic                   stop_cnt, stop_cnt_next;
  logic                   tx_next, busy_next, done_next;
  logic                   accept;
  logic                   bit_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state != IDLE),
    .bit_tick(bit_tick)
  );

  // State and output registers; reset forces an idle-high line immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      par_bit  <= par_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      tx       <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Next-state and next-output logic; tx changes only on bit boundaries.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    par_next      = par_bit;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    tx_next       = tx;
    busy_next     = busy;
    done_next     = 1'b0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          // Parity is captured here because the shift register is consumed.
          accept        = 1'b1;
          state_next    = START;
          shreg_next    = data;
          par_next      = (^data) ^ 1'(PARITY_ODD);
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          tx_next      = shreg[0];
          shreg_next   = shreg >> 1;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next      = shreg[0];
            shreg_next   = shreg >> 1;
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2) at 10
// clocks per bit, each compared cycle by cycle against a frame-level model.
module tb_uart_tx_serializer;

  localparam int CPB = 10;

  typedef struct {
    int         at;
    int         len;
    logic [7:0] d;
  } req_t;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] start_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] data_v [4];

  int   checks;
  int   failures;
  req_t reqs[$];

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .data(data_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .data(data_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .data(data_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .data(data_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_en(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int par_odd(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int stop_bits(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + 8 + par_en(i) + stop_bits(i)) * CPB;
  endfunction

  // Line level of bit slot b within a frame carrying d.
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par_en(i) == 1 && b == 9) return (^d) ^ 1'(par_odd(i));
    return 1'b1;
  endfunction

  // Drive the queued requests into instance i for n cycles, comparing every
  // cycle. The model remembers only the last accepted frame: a request is
  // taken when the edge falls after that frame's done cycle began.
  task automatic run_scenario(input string name, input int i, input int n, input int rst_at);
    int         acc_t;
    logic [7:0] acc_d;
    int         k;
    logic       s;
    logic [7:0] dv;
    logic       e_tx, e_busy, e_done;
    acc_t = -1000000;
    acc_d = 8'h00;
    for (int c = 0; c < n; c++) begin
      s  = 1'b0;
      dv = 8'($urandom);
      foreach (reqs[r]) begin
        if (c >= reqs[r].at && c < reqs[r].at + reqs[r].len) begin
          s  = 1'b1;
          dv = reqs[r].d;
        end
      end
      start_v[i] = s;
      data_v[i]  = dv;
      @(posedge clk);
      if (s && c >= acc_t + frame_len(i) + 1) begin
        acc_t = c;
        acc_d = dv;
      end
      #1 data_v[i] = 8'($urandom);
      k = c - acc_t;
      if (k >= 0 && k < frame_len(i)) begin
        e_tx = exp_bit(i, acc_d, k / CPB); e_busy = 1'b1; e_done = 1'b0;
      end else if (k == frame_len(i)) begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b1;
      end else begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
      @(negedge clk);
      checks += 3;
      if (tx_v[i] !== e_tx) begin
        failures++;
        $display("FAIL %s tx dut%0d cycle %0d: got %b expected %b", name, i, c, tx_v[i], e_tx);
      end
      if (busy_v[i] !== e_busy) begin
        failures++;
        $display("FAIL %s busy dut%0d cycle %0d: got %b expected %b", name, i, c, busy_v[i], e_busy);
      end
      if (done_v[i] !== e_done) begin
        failures++;
        $display("FAIL %s done dut%0d cycle %0d: got %b expected %b", name, i, c, done_v[i], e_done);
      end
      if (c == rst_at) begin
        #2 rst_v[i] = 1'b1;
        #1;
        checks += 2;
        if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0) begin
          failures++;
          $display("FAIL %s async_reset dut%0d: tx=%b busy=%b expected tx=1 busy=0", name, i, tx_v[i], busy_v[i]);
        end
        if (done_v[i] !== 1'b0) begin
          failures++;
          $display("FAIL %s async_reset_done dut%0d: got %b expected 0", name, i, done_v[i]);
        end
        #1 rst_v[i] = 1'b0;
        acc_t = -1000000;
      end
    end
    start_v[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_v   = 4'hF;
    start_v = 4'h0;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_async dut%0d: tx=%b busy=%b done=%b expected 1 0 0", i, tx_v[i], busy_v[i], done_v[i]);
      end
    end
    start_v = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_held dut%0d: tx=%b busy=%b done=%b expected 1 0 0", i, tx_v[i], busy_v[i], done_v[i]);
      end
    end
    start_v = 4'h0;
    rst_v   = 4'h0;
  endtask

  task automatic test_basic();
    reqs.delete();
    reqs.push_back('{2, 1, 8'hA5});
    run_scenario("basic_a5", 0, 2 + 100 + 6, -1);
  endtask

  task automatic test_parity();
    for (int i = 1; i <= 2; i++) begin
      reqs.delete();
      reqs.push_back('{2, 1, 8'h07});
      reqs.push_back('{2 + 110 + 4, 1, 8'($urandom)});
      run_scenario("parity", i, 2 + 230 + 6, -1);
    end
  endtask

  task automatic test_ignored();
    reqs.delete();
    reqs.push_back('{2, 4, 8'hA5});
    reqs.push_back('{52, 1, 8'hFF});
    reqs.push_back('{101, 1, 8'h81});
    run_scenario("ignored", 0, 2 + 100 + 6, -1);
  endtask

  task automatic test_back_to_back();
    reqs.delete();
    reqs.push_back('{2, 1, 8'hA5});
    reqs.push_back('{103, 1, 8'h3C});
    run_scenario("back_to_back", 0, 103 + 100 + 6, -1);
  endtask

  task automatic test_reset_mid();
    reqs.delete();
    reqs.push_back('{2, 1, 8'hA5});
    reqs.push_back('{45, 1, 8'h55});
    run_scenario("reset_mid", 0, 45 + 100 + 8, 37);
  endtask

  task automatic test_stop2();
    reqs.delete();
    reqs.push_back('{2, 1, 8'h00});
    run_scenario("stop2", 3, 2 + 110 + 6, -1);
  endtask

  task automatic test_random();
    int cur;
    for (int i = 0; i < 4; i++) begin
      reqs.delete();
      cur = 3;
      for (int r = 0; r < 6; r++) begin
        reqs.push_back('{cur, $urandom_range(1, 3), 8'($urandom)});
        cur += $urandom_range(frame_len(i) - 20, frame_len(i) + 20);
      end
      run_scenario("random", i, cur + frame_len(i) + 6, -1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_parity();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_stop2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
